// File: rtl/mem_arbiter_if.sv
// Bundle between mem_arbiter and its surroundings: the two requester ports
// and the single-port data memory.
//   slave  : the arbiter's view of the bundle.
//   master : the environment's view, i.e. both requesters and the memory.
// Handshake: a requester raises reqN and holds it, with weN/addrN/wdataN
// stable, until it sees the one-cycle ackN pulse. It drops reqN at the edge
// that ends the ack cycle. If reqN is still high in the following IDLE
// cycle, the arbiter treats it as a new request. rdataN is valid in the
// ack cycle of a read.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output ack0, rdata0, ack1, rdata1, mem_addr, mem_wdata, mem_read,
           mem_write, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  ack0, rdata0, ack1, rdata1, mem_addr, mem_wdata, mem_read,
           mem_write, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port data memory between the CPU datapath
// (port 0) and the loader/debug master (port 1). Each transaction takes
// three cycles: IDLE (grant and latch), ACCESS (one memory cycle) and
// RESP (one-cycle ack to the winner).
// Build option: MEM_ARB_FIXED_PRIO_EN makes port 0 always win contention.
// Without it, simultaneous requests alternate round-robin.
// o_state exposes the FSM state (0=IDLE, 1=ACCESS, 2=RESP).
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus,
  output logic [1:0]     o_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last_grant;
  logic              r_sel;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              w_any_req;
  logic              w_grant;

  // Pick the winning port for the current IDLE cycle (0 or 1).
  always_comb begin
    w_any_req = bus.req0 | bus.req1;
`ifdef MEM_ARB_FIXED_PRIO_EN
    // Port 1 is served only when port 0 is not asking.
    w_grant = !bus.req0;
`else
    // Under contention, the port that did not win last time goes next.
    if (bus.req0 && bus.req1) begin
      w_grant = !r_last_grant;
    end else begin
      w_grant = bus.req1;
    end
`endif
  end

  // FSM state register; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe outputs; strobes exist only in ACCESS/RESP.
  always_comb begin
    w_next        = r_state;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.ack0      = 1'b0;
    bus.ack1      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_next = ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_read  = !r_we;
        bus.mem_write = r_we;
        w_next        = RESP;
      end
      RESP: begin
        bus.ack0 = !r_sel;
        bus.ack1 = r_sel;
        w_next   = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Latch the winner's request in IDLE and capture read data at the end of ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_sel        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_sel   <= w_grant;
            r_we    <= w_grant ? bus.we1    : bus.we0;
            r_addr  <= w_grant ? bus.addr1  : bus.addr0;
            r_wdata <= w_grant ? bus.wdata1 : bus.wdata0;
          end
        end
        ACCESS: begin
          r_last_grant <= r_sel;
          if (!r_we) begin
            if (r_sel) begin
              r_rdata1 <= bus.mem_rdata;
            end else begin
              r_rdata0 <= bus.mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.busy      = (r_state != IDLE);
  assign o_state       = r_state;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer that shares the single-port 8-bit data memory between two requesters: port 0 is the CPU datapath, port 1 is the loader/debug master.
- Accepts one request at a time and drives the memory's Address/WriteData/MemRead/MemWrite lines for exactly one cycle.
- Returns read data with a one-cycle ack pulse to the winning requester.
- Sits between the requesters and the data memory instance.

Parameters:
- ADDR_W, 8, address width; memory depth is 2**ADDR_W.
- DATA_W, 8, data width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- req0  input  1  port 0 request; held high until ack0 is seen.
- we0  input  1  port 0 write enable; 1 = write, 0 = read. Stable while req0 is high.
- addr0  input  ADDR_W  port 0 address. Stable while req0 is high.
- wdata0  input  DATA_W  port 0 write data. Stable while req0 is high.
- ack0  output  1  port 0 completion pulse, one cycle.
- rdata0  output  DATA_W  port 0 read data; valid when ack0=1 for a read.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- mem_addr  output  ADDR_W  to memory Address.
- mem_wdata  output  DATA_W  to memory WriteData.
- mem_read  output  1  to memory MemRead.
- mem_write  output  1  to memory MemWrite.
- mem_rdata  input  DATA_W  from memory ReadData.
- busy  output  1  high in every state except IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. All state and output registers update on the rising edge of clk.
- Reset (rst=1 at an edge), taking priority over everything:
  - state=IDLE.
  - ack0=ack1=0; rdata0=rdata1=0.
  - Latched addr/wdata/we cleared.
  - last_grant=1, so port 0 wins the first contention.
  - Memory contents are untouched.
  - Reset mid-ACCESS or mid-RESP aborts the transaction: no ack is issued, and mem_write/mem_read are low from the next cycle.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, round-robin: grant the port that is not last_grant.
  - On grant: latch the port's addr, wdata and we, record the winner as sel, and go to ACCESS.
- ACCESS, one cycle:
  - mem_addr = latched addr; mem_wdata = latched wdata.
  - mem_write = latched we; mem_read = !latched we.
  - A write commits to memory at the edge ending ACCESS.
  - A read: mem_rdata is captured into rdata[sel] at the edge ending ACCESS; the other port's rdata holds.
  - last_grant <= sel. Go to RESP.
- RESP, one cycle:
  - ack[sel]=1; the other ack is 0.
  - mem_read=mem_write=0.
  - Requests are ignored. Go to IDLE.
- Outside ACCESS: mem_read=mem_write=0, and mem_addr/mem_wdata hold their last latched values.
- Latency: req first high in IDLE cycle N gives ACCESS in cycle N+1 and ack in cycle N+2. A transaction occupies 3 cycles.
- Handshake:
  - The requester drops req at the edge that ends its ack cycle.
  - A req still high in the IDLE cycle after RESP is treated as a new request.
  - The requester must not change we/addr/wdata while req is high. The arbiter latches them, so later changes have no effect on the current transaction.
- Back-to-back under continuous contention: grants alternate 0,1,0,1…, with each port served every 6 cycles.
- A req that drops while in IDLE before being granted is simply not served.
- For a write, rdata is unchanged.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins contention, and last_grant is ignored. Port 1 is served only when req0=0 in IDLE, so port 1 may starve.
- Undefined: round-robin as described above.
- All other timing is identical in both modes.

Test Plan:
- Memory preloaded with mem[100]=8'h83. Port 0 read, addr0=100, req0 at cycle N → mem_read=1 with mem_addr=100 at N+1; ack0=1 with rdata0=8'h83 at N+2; ack1 stays 0.
- Port 1 write, addr1=5, wdata1=8'h5A → mem_write=1 with mem_addr=5 and mem_wdata=8'h5A for exactly one cycle; ack1 follows. Then a port 0 read of addr 5 → rdata0=8'h5A.
- Right after reset, req0 and req1 rise in the same cycle and are held, reissued after each ack, for 4 transactions → ack order 0,1,0,1, with acks 3 cycles apart.
- rst asserted during ACCESS of a port 1 write to addr 7 (old value 8'h00) → no ack1; busy=0 the next cycle. Memory contents beyond the already-asserted cycle are not guaranteed; the bench checks only that no ack is issued and that the FSM returns to IDLE.
- MEM_ARB_FIXED_PRIO_EN defined, both ports requesting continuously for 4 transactions → ack0 only; ack1 is issued only after req0 drops.
- Idle bus with no req for 10 cycles → busy=0, mem_read=mem_write=0, no acks.
